// File: rtl/mul_div_unit_pkg.sv
// Shared types and op-class helpers for the iterative multiply/divide unit.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    OpMul      = 3'd0,
    OpMulhu    = 3'd1,
    OpMulhs    = 3'd2,
    OpUdiv     = 3'd3,
    OpSdiv     = 3'd4,
    OpUmod     = 3'd5,
    OpSmod     = 3'd6,
    OpReserved = 3'd7
  } mul_div_oper_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StFixup,
    StDone
  } state_e;

  localparam logic [2:0] OP_RESERVED = 3'd7;

  function automatic logic is_signed(mul_div_oper_e op);
    return op inside {OpMulhs, OpSdiv, OpSmod};
  endfunction

  function automatic logic is_div(mul_div_oper_e op);
    return op inside {OpUdiv, OpSdiv, OpUmod, OpSmod};
  endfunction

  function automatic logic is_mod(mul_div_oper_e op);
    return op inside {OpUmod, OpSmod};
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One combinational iteration: shift-add multiply or restoring divide on a 2W accumulator.
module mul_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               qbit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] top;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    top      = acc[2*WIDTH-1:WIDTH-1];
    diff     = top - {1'b0, operand};
    qbit     = 1'b0;
    acc_next = '0;
    if (mode) begin
      // Remainder stays below the divisor, so diff[WIDTH] is a clean borrow flag.
      qbit     = ~diff[WIDTH];
      acc_next = {(qbit ? diff[WIDTH-1:0] : top[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: WIDTH iterations per op, early exit for div-by-0,
// signed overflow and the reserved op; result held until the consumer accepts it.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_oper,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod;
  logic [WIDTH-1:0]   opnd_q, opnd_d, out_data_q, out_data_d;
  logic [WIDTH-1:0]   mag_a, mag_b, early_data, fix_data;
  mul_div_oper_e      op_q, op_d, oper;
  logic               neg_q, neg_d;
  logic               a_neg, b_neg, div_zero, overflow, early, step_qbit;

  assign oper = mul_div_oper_e'(in_oper);

  mul_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode    (is_div(op_q)),
    .acc     (acc_q),
    .operand (opnd_q),
    .acc_next(step_acc),
    .qbit    (step_qbit)
  );

  // Accept-time decode: magnitudes, early cases and their direct results.
  always_comb begin
    a_neg      = is_signed(oper) && in_a[WIDTH-1];
    b_neg      = is_signed(oper) && in_b[WIDTH-1];
    mag_a      = a_neg ? -in_a : in_a;
    mag_b      = b_neg ? -in_b : in_b;
    div_zero   = is_div(oper) && (in_b == '0);
    overflow   = is_div(oper) && is_signed(oper) && (in_a == MOST_NEG) && (in_b == '1);
    early      = (in_oper == OP_RESERVED) || div_zero || overflow;
    early_data = '0;
    if (div_zero) begin
      early_data = is_mod(oper) ? in_a : '1;
    end else if (overflow) begin
      early_data = is_mod(oper) ? '0 : MOST_NEG;
    end
  end

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    if (is_mod(op_q)) begin
      fix_data = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end else if (is_div(op_q)) begin
      fix_data = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end else if (op_q == OpMul) begin
      fix_data = acc_q[WIDTH-1:0];
    end else begin
      fix_data = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    op_d       = op_q;
    neg_d      = neg_q;
    out_data_d = out_data_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d = oper;
          if (early) begin
            out_data_d = early_data;
            state_d    = StDone;
          end else begin
            state_d = StBusy;
            cnt_d   = CNT_LAST;
            acc_d   = is_div(oper) ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
            opnd_d  = is_div(oper) ? mag_b : mag_a;
            neg_d   = is_mod(oper) ? a_neg : (a_neg ^ b_neg);
          end
        end
      end
      StBusy: begin
        acc_d = {step_acc[2*WIDTH-1:1], step_acc[0] | step_qbit};
        if (cnt_q == '0) begin
          state_d = StFixup;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StFixup: begin
        out_data_d = fix_data;
        state_d    = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      op_q       <= OpMul;
      neg_q      <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: arithmetic reference model, per-cycle monitor,
// directed corner cases and randomized traffic with backpressure and resets.
module tb_mul_div_unit;

  localparam int W = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_oper = 3'd0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bit          mon_en = 1'b0;
  bit          pend = 1'b0;
  int          age = 0;
  int          lat = 0;
  logic [31:0] exp_q = '0;

  mul_div_unit #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_oper  (in_oper),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0]        pu;
    logic signed [63:0] sa, sb, ps, q;
    logic               ovf;
    pu  = {32'd0, a} * {32'd0, b};
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ps  = sa * sb;
    ovf = (a == MIN) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: return pu[31:0];
      3'd1: return pu[63:32];
      3'd2: return ps[63:32];
      3'd3: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return MIN;
        q = sa / sb;
        return q[31:0];
      end
      3'd5: return (b == 0) ? a : a % b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        q = sa % sb;
        return q[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_early(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
    return (op == 3'd7) || (op >= 3'd3 && op <= 3'd6 && b == 0) ||
           ((op == 3'd4 || op == 3'd6) && a == MIN && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return MIN;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares outputs each cycle, then advances the transaction model by one edge.
  initial begin
    logic vexp;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        vexp = pend && (age >= lat);
        check("mon_out_valid", {31'd0, out_valid}, {31'd0, vexp});
        check("mon_in_ready", {31'd0, in_ready}, {31'd0, !pend});
        check("mon_busy", {31'd0, busy}, {31'd0, pend});
        if (vexp) check("mon_out_data", out_data, exp_q);
      end
      if (rst) begin
        pend = 1'b0;
      end else if (!pend) begin
        if (in_valid) begin
          pend  = 1'b1;
          age   = 0;
          exp_q = model(in_oper, in_a, in_b);
          lat   = is_early(in_oper, in_a, in_b) ? 0 : W + 1;
        end
      end else if (age >= lat && out_ready) begin
        pend = 1'b0;
      end else begin
        age++;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("issue_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_oper  = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_oper  = 3'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic directed(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int k;
    issue(op, a, b);
    wait_valid(k);
    check({name, "_lat"}, k, exp_lat);
    check({name, "_data"}, out_data, exp);
    retire();
    check({name, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int          k;
    logic [31:0] hold, ra, rb;
    logic [2:0]  rop;
    bit          pre;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    mon_en = 1'b1;

    directed("mul", 3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33);
    directed("mulhu", 3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33);
    directed("mulhs", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
    directed("sdiv", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    directed("smod", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    directed("udiv0", 3'd3, 32'd100, 32'd0, 32'hFFFF_FFFF, 0);
    directed("umod0", 3'd5, 32'd100, 32'd0, 32'd100, 0);
    directed("sdiv_ovf", 3'd4, MIN, 32'hFFFF_FFFF, MIN, 0);
    directed("smod_ovf", 3'd6, MIN, 32'hFFFF_FFFF, 32'd0, 0);
    directed("sdiv0", 3'd4, 32'd7, 32'd0, 32'hFFFF_FFFF, 0);
    directed("smod0", 3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);
    directed("resv", 3'd7, 32'd9, 32'd3, 32'd0, 0);
    directed("mulhs_min", 3'd2, MIN, MIN, 32'h4000_0000, 33);

    // Backpressure: result must hold while in_valid is waved at a full unit.
    ra = $urandom;
    rb = $urandom;
    issue(3'd0, ra, rb);
    wait_valid(k);
    check("bp_lat", k, 33);
    hold = out_data;
    check("bp_result", hold, model(3'd0, ra, rb));
    in_valid = 1'b1;
    in_oper  = 3'd3;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_data", out_data, hold);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle", {31'd0, in_ready}, 32'd1);

    // Reset ten cycles into a multiply.
    issue(3'd1, $urandom, $urandom);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstbusy_in_ready", {31'd0, in_ready}, 32'd1);
    check("rstbusy_out_valid", {31'd0, out_valid}, 32'd0);
    check("rstbusy_busy", {31'd0, busy}, 32'd0);
    repeat (40) begin
      @(posedge clk); #1;
    end
    directed("udiv_after_rst", 3'd3, 32'd100, 32'd7, 32'd14, 33);

    // Reset coinciding with a request drops the request.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_oper  = 3'd3;
    in_a     = 32'd50;
    in_b     = 32'd5;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rstreq_in_ready", {31'd0, in_ready}, 32'd1);
    check("rstreq_busy", {31'd0, busy}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end

    for (int i = 0; i < 300; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      pre = ($urandom_range(0, 3) == 0);
      if (pre) out_ready = 1'b1;
      issue(rop, ra, rb);
      wait_valid(k);
      check("rnd_lat", k, is_early(rop, ra, rb) ? 0 : 33);
      if (pre) begin
        @(posedge clk); #1;
        out_ready = 1'b0;
      end else begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
        retire();
      end
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative, parametrised multiply/divide unit sitting beside the single-cycle combinational ALU in the execute stage. It accepts one operation at a time over a valid/ready handshake and computes the result in WIDTH iterations: radix-2 shift-add for multiplies, restoring division for divides. Divide-by-zero and signed-overflow cases complete early. The result is held until the consumer accepts it.

## Interface
- WIDTH, default 32: operand and result width. Must be at least 4.
- CNT_W, default $clog2(WIDTH): iteration counter width, derived, not overridden.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in Idle.
- in_oper  in  3  PkgMulDiv::MulDivOper.
- in_a  in  WIDTH  multiplicand / dividend.
- in_b  in  WIDTH  multiplier / divisor.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result.
- busy  out  1  high in Busy or Done.

## Operation
- Operation codes:
  - 0 Mul: low W bits of the product.
  - 1 Mulhu: high W bits, unsigned×unsigned.
  - 2 Mulhs: high W bits, signed×signed.
  - 3 Udiv, 4 Sdiv, 5 Umod, 6 Smod.
  - 7 is reserved: result 0, early completion.
- Signed ops: latch |a| and |b| at accept, plus the result sign.
  - Product sign is a^b.
  - Quotient sign is a^b.
  - Remainder sign is the sign of a.
  - The sign is applied in the Fixup cycle by two's-complement negation of the 2W product, the quotient, or the remainder.
- Divide by zero:
  - quotient is all-ones, for both Udiv and Sdiv.
  - remainder equals in_a.
- Sdiv with in_a = most-negative and in_b = -1: quotient is most-negative, remainder is 0.
- Division truncates toward zero. The sign of the remainder follows the dividend.
- States: Idle, Busy, Fixup, Done (enum in the package).
  - Idle → Busy on in_valid, for a normal op.
  - Idle → Done on in_valid, for early cases (div-by-0, overflow, reserved). The result is written directly.
  - Busy: one iteration per cycle while the counter runs WIDTH-1 down to 0. At count 0 → Fixup.
  - Fixup: apply sign and select the output half → Done.
  - Done → Idle when out_ready is high.
- out_data is registered and stays stable throughout Done.
- in_a, in_b and in_oper are sampled only on the accept edge. Later changes are ignored.

## Timing
- Reset values:
  - state is Idle.
  - in_ready = 1, out_valid = 0, busy = 0.
  - out_data = 0, counter = 0.
- Normal op: accepted at edge E0. out_valid is high from edge E0+WIDTH+1 onward, so latency is WIDTH+1 cycles (33 for WIDTH = 32).
- Early op: out_valid is high one cycle after accept.
- in_ready is combinational from state (Idle only) and does not depend on in_valid.
- out_valid with out_ready low: hold state, out_valid and out_data indefinitely.
- out_valid and out_ready both high: Idle next cycle. A new request can be accepted no earlier than the following edge, so there is no same-cycle turnaround.
- rst asserted in any state: Idle on the next edge. Any partial result is discarded and out_valid is not raised.
- rst asserted together with in_valid: the request is dropped.
- Counter wraps never. It is loaded with WIDTH-1 on accept.

## Structure
- PkgMulDiv holds:
  - the MulDivOper enum (3 bits) and the State enum (2 bits);
  - localparams OP_RESERVED and the op-class helpers is_signed, is_div and is_mod as functions.
- Sub-module mul_div_step: purely combinational, one iteration.
  - Inputs: mode (mul/div), accumulator (2W), operand (W).
  - Outputs: next accumulator and the quotient bit.
  - Instantiated once.
- The top level holds the state machine, counter, sign capture, early-case detection and the Fixup mux.

## Test plan
- Mul, a = 0x0001_0000, b = 0x0001_0000:
  - out_data = 0x0000_0000 at E0+33.
  - The same operands with Mulhu give 0x0000_0001.
- Mulhs, a = 0xFFFF_FFFF (-1), b = 0x0000_0002: out_data = 0xFFFF_FFFF. Sdiv, a = -7, b = 2: 0xFFFF_FFFD (-3). Smod on the same operands: 0xFFFF_FFFF (-1).
- Udiv, a = 100, b = 0: out_valid one cycle after accept, out_data = 0xFFFF_FFFF. Umod on the same operands: 100.
- Sdiv, a = 0x8000_0000, b = 0xFFFF_FFFF: early, out_data = 0x8000_0000. Smod on the same operands: 0.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid.
  - out_data is stable and in_ready = 0 throughout.
  - A later out_ready pulse returns the unit to Idle next cycle.
- Reset mid-Busy (cycle 10 of 33): Idle next edge, out_valid never rises. A fresh Udiv 100/7 then returns 14 at E0+33.
